// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEYEXP,
        S_ADD0,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int          NR_DEF    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RCON_POLY = 8'h1B;

endpackage

// File: rtl/aes_rcon_step.sv
// GF(2^8) xtime: multiply a byte by x modulo the AES polynomial.
// Used for the rcon sequence and shared with the MixColumns datapath.
module aes_rcon_step
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    assign byte_out = {byte_in[6:0], 1'b0} ^ (byte_in[7] ? RCON_POLY : 8'h00);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encryption control sequencer: key expansion, round 0, NR rounds, done handshake.
// Optional round-key reuse across starts is enabled by defining AES_KEY_CACHE_EN.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = NR_DEF,
    parameter int RK_AW = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             engine_start,
    input  logic             key_new,
    input  logic             rnd_ready,
    output logic             transformer_done,
    output logic             ld_state,
    output logic             ks_we,
    output logic [RK_AW-1:0] rk_addr,
    output logic [7:0]       rcon,
    output logic             add_key_only,
    output logic             round_en,
    output logic             skip_mix,
    output logic             out_valid
);

    localparam int            CW        = $clog2(NR + 1);
    localparam logic [CW-1:0] LAST_RND  = CW'(NR);
    localparam logic [CW-1:0] LAST_FULL = CW'(NR - 1);

    state_t        state;
    logic [CW-1:0] rnd_cnt;
    logic [7:0]    rcon_next;
    logic          use_cache;

    aes_rcon_step u_rcon_step (
        .byte_in  (rcon),
        .byte_out (rcon_next)
    );

    // The round counter doubles as the round-key address in every phase.
    assign rk_addr = RK_AW'(rnd_cnt);

`ifdef AES_KEY_CACHE_EN
    logic key_cached;
    logic key_stale;

    assign use_cache = key_cached & ~key_stale;

    // A key arriving mid-run marks the keys stale, so the run in flight
    // finishing KEYEXP cannot make the old schedule look reusable.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            key_cached <= 1'b0;
            key_stale  <= 1'b0;
        end else begin
            if (state == S_KEYEXP && rnd_ready && rnd_cnt == LAST_RND)
                key_cached <= 1'b1;
            if (state == S_LOAD && !use_cache)
                key_stale <= 1'b0;
            if (key_new) begin
                key_cached <= 1'b0;
                if (state != S_IDLE)
                    key_stale <= 1'b1;
            end
        end
    end
`else
    logic unused_key_new;

    assign use_cache      = 1'b0;
    assign unused_key_new = key_new;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state            <= S_IDLE;
            rnd_cnt          <= '0;
            rcon             <= RCON_INIT;
            transformer_done <= 1'b1;
            ld_state         <= 1'b0;
            ks_we            <= 1'b0;
            add_key_only     <= 1'b0;
            round_en         <= 1'b0;
            skip_mix         <= 1'b0;
            out_valid        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (engine_start) begin
                        state            <= S_LOAD;
                        transformer_done <= 1'b0;
                        ld_state         <= 1'b1;
                    end
                end
                S_LOAD: begin
                    ld_state <= 1'b0;
                    if (use_cache) begin
                        state        <= S_ADD0;
                        add_key_only <= 1'b1;
                        rnd_cnt      <= '0;
                    end else begin
                        state   <= S_KEYEXP;
                        ks_we   <= 1'b1;
                        rnd_cnt <= CW'(1);
                        rcon    <= RCON_INIT;
                    end
                end
                // Step states only move on rnd_ready; a stall holds every output.
                S_KEYEXP: begin
                    if (rnd_ready) begin
                        if (rnd_cnt == LAST_RND) begin
                            state        <= S_ADD0;
                            ks_we        <= 1'b0;
                            add_key_only <= 1'b1;
                            rnd_cnt      <= '0;
                        end else begin
                            rnd_cnt <= rnd_cnt + CW'(1);
                            rcon    <= rcon_next;
                        end
                    end
                end
                S_ADD0: begin
                    if (rnd_ready) begin
                        add_key_only <= 1'b0;
                        round_en     <= 1'b1;
                        rnd_cnt      <= CW'(1);
                        if (NR == 1) begin
                            state    <= S_FINAL;
                            skip_mix <= 1'b1;
                        end else begin
                            state <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    if (rnd_ready) begin
                        rnd_cnt <= rnd_cnt + CW'(1);
                        if (rnd_cnt == LAST_FULL) begin
                            state    <= S_FINAL;
                            skip_mix <= 1'b1;
                        end
                    end
                end
                S_FINAL: begin
                    if (rnd_ready) begin
                        state     <= S_DONE;
                        round_en  <= 1'b0;
                        skip_mix  <= 1'b0;
                        out_valid <= 1'b1;
                        rnd_cnt   <= '0;
                    end
                end
                S_DONE: begin
                    state            <= S_IDLE;
                    out_valid        <= 1'b0;
                    transformer_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: per-cycle vector tables plus
// hand-written multi-cycle sequences (stall, restart, async reset, key cache).
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_;
    logic       engine_start;
    logic       key_new;
    logic       rnd_ready;
    logic       transformer_done;
    logic       ld_state;
    logic       ks_we;
    logic [3:0] rk_addr;
    logic [7:0] rcon;
    logic       add_key_only;
    logic       round_en;
    logic       skip_mix;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .RK_AW(4)) dut (
        .clk              (clk),
        .rst_             (rst_),
        .engine_start     (engine_start),
        .key_new          (key_new),
        .rnd_ready        (rnd_ready),
        .transformer_done (transformer_done),
        .ld_state         (ld_state),
        .ks_we            (ks_we),
        .rk_addr          (rk_addr),
        .rcon             (rcon),
        .add_key_only     (add_key_only),
        .round_en         (round_en),
        .skip_mix         (skip_mix),
        .out_valid        (out_valid)
    );

    // Output flag groups {done, ld, we, add0, round_en, skip_mix, out_valid}
    localparam logic [6:0] F_IDLE = 7'b1000000;
    localparam logic [6:0] F_LOAD = 7'b0100000;
    localparam logic [6:0] F_KEY  = 7'b0010000;
    localparam logic [6:0] F_ADD0 = 7'b0001000;
    localparam logic [6:0] F_RND  = 7'b0000100;
    localparam logic [6:0] F_FIN  = 7'b0000110;
    localparam logic [6:0] F_DONE = 7'b0000001;
    localparam logic [18:0] RESET_OUTS = {F_IDLE, 4'h0, 8'h01};

    typedef struct {
        logic        start;
        logic        knew;
        logic        ready;
        logic [18:0] exp;
        logic [18:0] mask;
    } vec_t;

    vec_t       vec[$];
    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    function automatic logic [18:0] outs();
        return {transformer_done, ld_state, ks_we, add_key_only, round_en,
                skip_mix, out_valid, rk_addr, rcon};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic k, input logic r, input logic [6:0] fl,
                        input logic [3:0] a, input logic [7:0] rc, input bit chk_a, input bit chk_rc);
        vec_t v;
        v.start = s;
        v.knew  = k;
        v.ready = r;
        v.exp   = {fl, a, rc};
        v.mask  = {7'h7f, chk_a ? 4'hf : 4'h0, chk_rc ? 8'hff : 8'h00};
        vec.push_back(v);
    endtask

    // One full run starting with a key_new pulse in IDLE; optional 3-cycle stall at round 5.
    task automatic build_run(input bit stall);
        vec.delete();
        push(0, 1, 1, F_IDLE, 4'd0, 8'h00, 0, 0);
        push(1, 0, 1, F_LOAD, 4'd0, 8'h00, 1, 0);
        for (int i = 1; i <= 10; i++)
            push(0, 0, 1, F_KEY, 4'(i), rc_tab[i-1], 1, 1);
        push(0, 0, 1, F_ADD0, 4'd0, 8'h00, 1, 0);
        for (int r = 1; r <= 9; r++) begin
            push(0, 0, 1, F_RND, 4'(r), 8'h00, 1, 0);
            if (stall && r == 5)
                for (int s = 0; s < 3; s++)
                    push(0, 0, 0, F_RND, 4'd5, 8'h00, 1, 0);
        end
        push(0, 0, 1, F_FIN, 4'd10, 8'h00, 1, 0);
        push(0, 0, 1, F_DONE, 4'd0, 8'h00, 0, 0);
        push(0, 0, 1, F_IDLE, 4'd0, 8'h00, 0, 0);
    endtask

    task automatic apply(input string tag, input int exp_busy);
        int busy = 0;
        foreach (vec[i]) begin
            engine_start = vec[i].start;
            key_new      = vec[i].knew;
            rnd_ready    = vec[i].ready;
            tick();
            if (!transformer_done) busy++;
            check($sformatf("%s row %0d", tag, i), 32'(outs() & vec[i].mask),
                  32'(vec[i].exp & vec[i].mask));
        end
        engine_start = 1'b0;
        key_new      = 1'b0;
        rnd_ready    = 1'b1;
        check({tag, " busy cycles"}, busy, exp_busy);
    endtask

    // Start one run and measure it; optional engine_start / key_new pulses at busy cycle N.
    task automatic run_measure(input string tag, input int pulse_at, input int knew_at,
                               output int busy, output int n_ov, output int n_we, output int ov_at);
        busy  = 0;
        n_ov  = 0;
        n_we  = 0;
        ov_at = 0;
        engine_start = 1'b1;
        tick();
        engine_start = 1'b0;
        for (int c = 1; c < 100; c++) begin
            if (transformer_done) break;
            busy++;
            if (out_valid) begin
                n_ov++;
                ov_at = busy;
            end
            if (ks_we) n_we++;
            engine_start = (c == pulse_at);
            key_new      = (c == knew_at);
            tick();
        end
        engine_start = 1'b0;
        key_new      = 1'b0;
        check({tag, " finished"}, transformer_done, 1);
    endtask

    initial begin
        int busy, n_ov, n_we, ov_at;
        bit found;

        rst_         = 1'b0;
        engine_start = 1'b0;
        key_new      = 1'b0;
        rnd_ready    = 1'b1;
        tick();
        tick();
        check("reset outputs", outs(), RESET_OUTS);
        rst_ = 1'b1;
        tick();

        build_run(0);
        apply("nominal", 23);
        build_run(1);
        apply("stall", 26);

        // Start pulse during KEYEXP must be ignored.
        key_new = 1'b1;
        tick();
        key_new = 1'b0;
        run_measure("keyexp pulse", 4, 0, busy, n_ov, n_we, ov_at);
        check("keyexp pulse busy", busy, 23);
        check("keyexp pulse out_valid count", n_ov, 1);
        check("keyexp pulse out_valid cycle", ov_at, 23);
        check("keyexp pulse ks_we count", n_we, 10);
        tick();
        check("keyexp pulse no restart", transformer_done, 1);

        // engine_start held across DONE restarts straight from IDLE.
        engine_start = 1'b1;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            found = out_valid;
        end
        check("held start out_valid seen", found, 1);
        tick();
        check("held start idle after done", {transformer_done, ld_state}, 2'b10);
        tick();
        check("held start reload", {transformer_done, ld_state}, 2'b01);
        engine_start = 1'b0;
        for (int c = 0; c < 60 && !transformer_done; c++) tick();
        check("held start second run ends", transformer_done, 1);
        tick();

`ifdef AES_KEY_CACHE_EN
        run_measure("cache hit", 0, 0, busy, n_ov, n_we, ov_at);
        check("cache hit busy", busy, 13);
        check("cache hit ks_we count", n_we, 0);
        check("cache hit out_valid cycle", ov_at, 13);
        run_measure("key_new mid-run", 0, 5, busy, n_ov, n_we, ov_at);
        check("key_new mid-run busy", busy, 13);
        check("key_new mid-run ks_we count", n_we, 0);
        run_measure("after key_new", 0, 0, busy, n_ov, n_we, ov_at);
        check("after key_new busy", busy, 23);
        check("after key_new ks_we count", n_we, 10);
        tick();
`endif

        // Asynchronous reset in the middle of round 4.
        engine_start = 1'b1;
        tick();
        engine_start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (round_en && rk_addr == 4'd4) found = 1;
            else tick();
        end
        check("reached round 4", found, 1);
        #2;
        rst_ = 1'b0;
        #1;
        check("async reset outputs", outs(), RESET_OUTS);
        tick();
        tick();
        rst_ = 1'b1;
        tick();
        run_measure("after reset", 0, 0, busy, n_ov, n_we, ov_at);
        check("after reset busy", busy, 23);
        check("after reset ks_we count", n_we, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
